instr_sequencer: RTL and testbench

//  Fetch/issue sequencer for the Aeolus control path. Reads 4-bit opcodes from program memory at PC.

---
 rtl/instr_sequencer.sv | 131 +++++++++++++
 tb/tb_instr_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Fetch/issue sequencer for the Aeolus control path.
// Reads 4-bit opcodes from program memory at PC and presents each one to the decoder
// through a valid/ready handshake. Supports free-run, single-step, halt request and restart.
//
// Ports:
//   CLKin, nRST      clock (rising edge) and asynchronous active-low reset
//   run              level, fetch/issue continuously while not halted
//   step             pulse in idle, fetch/issue exactly one instruction
//   halt_req         pulse, stop after the current instruction completes
//   restart          pulse in idle/halt, PC <= 0 and go idle
//   mem_addr/mem_rd  program memory address (= PC) and one-cycle read strobe
//   mem_data/valid   opcode returned by memory, accepted only while waiting for it
//   instr_out/valid  opcode presented to the decoder, held until instr_ready
//   instr_ready      datapath accepted the opcode this cycle
//   pc_out           current PC
//   busy, halted     status: instruction in flight / stopped on PC wrap
module instr_sequencer #(
   parameter int unsigned PC_WIDTH     = 4,
   parameter bit          HALT_ON_WRAP = 1'b1
) (
   input  logic                CLKin,
   input  logic                nRST,
   input  logic                run,
   input  logic                step,
   input  logic                halt_req,
   input  logic                restart,
   output logic [PC_WIDTH-1:0] mem_addr,
   output logic                mem_rd,
   input  logic [3:0]          mem_data,
   input  logic                mem_valid,
   output logic [3:0]          instr_out,
   output logic                instr_valid,
   input  logic                instr_ready,
   output logic [PC_WIDTH-1:0] pc_out,
   output logic                busy,
   output logic                halted
);

   typedef enum logic [2:0] {StIdle, StFetch, StWait, StIssue, StHalt} state_e;

   state_e              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [3:0]          instr_q, instr_d;
   logic                halt_pend_q, halt_pend_d;
   logic                step_mode_q, step_mode_d;
   logic                pc_at_max;

   assign pc_at_max = (pc_q == {PC_WIDTH{1'b1}});

   always_ff @(posedge CLKin or negedge nRST) begin
      if (!nRST) begin
         state_q     <= StIdle;
         pc_q        <= '0;
         instr_q     <= '0;
         halt_pend_q <= 1'b0;
         step_mode_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         halt_pend_q <= halt_pend_d;
         step_mode_q <= step_mode_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      halt_pend_d = halt_pend_q;
      step_mode_d = step_mode_q;

      unique case (state_q)
         StIdle: begin
            if (run) begin
               state_d     = StFetch;
               step_mode_d = 1'b0;
            end else if (step) begin
               state_d     = StFetch;
               step_mode_d = 1'b1;
            end else if (restart) begin
               pc_d = '0;
            end
         end
         StFetch: state_d = StWait;
         StWait: begin
            if (mem_valid) begin
               instr_d = mem_data;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (instr_ready) begin
               pc_d = pc_q + 1'b1;
               // halt_req coincident with the handshake already counts as pending
               if (pc_at_max && HALT_ON_WRAP) begin
                  state_d = StHalt;
               end else if (halt_pend_q || halt_req || step_mode_q || !run) begin
                  state_d = StIdle;
               end else begin
                  state_d = StFetch;
               end
            end
         end
         StHalt: begin
            if (restart) begin
               pc_d    = '0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (halt_req && (state_q == StFetch || state_q == StWait || state_q == StIssue)) begin
         halt_pend_d = 1'b1;
      end
      // Pending halt is consumed by reaching idle or halt
      if (state_d == StIdle || state_d == StHalt) begin
         halt_pend_d = 1'b0;
      end
   end

   assign mem_addr    = pc_q;
   assign pc_out      = pc_q;
   assign mem_rd      = (state_q == StFetch);
   assign instr_out   = instr_q;
   assign instr_valid = (state_q == StIssue);
   assign busy        = (state_q == StFetch) || (state_q == StWait) || (state_q == StIssue);
   assign halted      = (state_q == StHalt);

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: bench acts as program memory and datapath, and a
// behavioural model tracks the instruction lifecycle, PC and halt/step bookkeeping.
module tb_instr_sequencer;

   localparam int PcMax = 15;
   localparam int PhFetch = 0, PhWait = 1, PhIssue = 2;

   logic       CLKin, nRST;
   logic       run, step, halt_req, restart;
   logic [3:0] mem_addr, mem_data, instr_out, pc_out;
   logic       mem_rd, mem_valid, instr_valid, instr_ready, busy, halted;

   instr_sequencer dut (
      .CLKin       (CLKin),
      .nRST        (nRST),
      .run         (run),
      .step        (step),
      .halt_req    (halt_req),
      .restart     (restart),
      .mem_addr    (mem_addr),
      .mem_rd      (mem_rd),
      .mem_data    (mem_data),
      .mem_valid   (mem_valid),
      .instr_out   (instr_out),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .pc_out      (pc_out),
      .busy        (busy),
      .halted      (halted)
   );

   initial CLKin = 1'b0;
   always #5 CLKin = ~CLKin;

   int n_chk = 0;
   int n_bad = 0;

   // program memory contents
   logic [3:0] prog [16];

   // reference model
   logic m_busy, m_halted, m_pend, m_step;
   int   m_phase, m_pc, hs_count;

   // memory / datapath behaviour knobs
   int   lat_max, stall_max, wait_left, stall_left;
   logic lat_rand, stall_rand, stray_en;
   logic [3:0] rd_addr;
   int   rd_cnt, valid_cnt;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic sample_checks();
      if (mem_rd) begin
         rd_addr = mem_addr;
         rd_cnt++;
      end
      if (instr_valid) valid_cnt++;
      check_eq("busy", busy, m_busy);
      check_eq("halted", halted, m_halted);
      check_eq("pc_out", pc_out, m_pc);
      check_eq("mem_addr", mem_addr, m_pc);
      check_eq("mem_rd", mem_rd, m_busy && m_phase == PhFetch);
      check_eq("instr_valid", instr_valid, m_busy && m_phase == PhIssue);
      if (m_busy && m_phase == PhIssue) check_eq("instr_out", instr_out, prog[m_pc]);
   endtask

   task automatic model_reset();
      m_busy = 0; m_halted = 0; m_pend = 0; m_step = 0;
      m_phase = PhFetch; m_pc = 0;
   endtask

   // One clock cycle: drive inputs, advance the model across the edge, then check outputs.
   task automatic cycle(input logic r, input logic s, input logic h, input logic rs);
      logic       mv, rdy;
      logic [3:0] md;
      run = r; step = s; halt_req = h; restart = rs;
      mv = 1'b0;
      md = 4'($urandom);
      if (m_busy && m_phase == PhWait) begin
         if (wait_left == 0) begin
            mv = 1'b1;
            md = prog[rd_addr];
         end else begin
            wait_left--;
         end
      end else if (stray_en && $urandom_range(0, 3) == 0) begin
         mv = 1'b1;
      end
      rdy = 1'($urandom_range(0, 1));
      if (m_busy && m_phase == PhIssue) begin
         rdy = (stall_left == 0);
         if (stall_left > 0) stall_left--;
      end
      mem_valid = mv; mem_data = md; instr_ready = rdy;

      if (m_halted) begin
         if (rs) begin m_halted = 0; m_pc = 0; end
      end else if (!m_busy) begin
         if (r) begin m_busy = 1; m_phase = PhFetch; m_step = 0; end
         else if (s) begin m_busy = 1; m_phase = PhFetch; m_step = 1; end
         else if (rs) m_pc = 0;
      end else begin
         if (h) m_pend = 1;
         if (m_phase == PhFetch) begin
            m_phase   = PhWait;
            wait_left = lat_rand ? int'($urandom_range(0, lat_max)) : lat_max;
         end else if (m_phase == PhWait) begin
            if (mv) begin
               m_phase    = PhIssue;
               stall_left = stall_rand ? int'($urandom_range(0, stall_max)) : stall_max;
            end
         end else if (rdy) begin
            hs_count++;
            if (m_pc == PcMax) begin
               m_pc = 0; m_busy = 0; m_halted = 1; m_pend = 0;
            end else begin
               m_pc++;
               if (m_pend || m_step || !r) begin m_busy = 0; m_pend = 0; end
               else m_phase = PhFetch;
            end
         end
      end
      @(posedge CLKin);
      #1;
      sample_checks();
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && m_busy; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Issue n instructions in free-run mode, dropping run during the last one.
   task automatic run_instrs(input int n);
      int target;
      target = hs_count + n;
      for (int i = 0; i < 3000 && (hs_count < target || m_busy); i++)
         cycle((hs_count < target - 1) || (!m_busy && hs_count < target), 1'b0, 1'b0, 1'b0);
   endtask

   task automatic set_knobs(input int lat, input int stall, input logic rnd);
      lat_max = lat; stall_max = stall; lat_rand = rnd; stall_rand = rnd; stray_en = rnd;
   endtask

   initial begin
      int   rd0, v0;
      logic hp, halt_done;
      run = 0; step = 0; halt_req = 0; restart = 0;
      mem_valid = 0; mem_data = 0; instr_ready = 0;
      hs_count = 0; rd_cnt = 0; valid_cnt = 0; rd_addr = 0;
      wait_left = 0; stall_left = 0;
      for (int i = 0; i < 16; i++) prog[i] = 4'($urandom);
      model_reset();
      set_knobs(0, 0, 1'b0);

      // reset state
      nRST = 1'b1;
      #2 nRST = 1'b0;
      @(posedge CLKin);
      @(posedge CLKin);
      #1;
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_mem_rd", mem_rd, 0);
      check_eq("rst_instr_out", instr_out, 0);
      check_eq("rst_instr_valid", instr_valid, 0);
      check_eq("rst_pc_out", pc_out, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_halted", halted, 0);
      nRST = 1'b1;

      // free-run of opcodes 0..3, memory answers one cycle after read, ready always high
      for (int i = 0; i < 4; i++) prog[i] = 4'(i);
      run_instrs(4);
      check_eq("freerun_pc", pc_out, 4);

      // single step at PC=2
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 1'b0); drain();
      cycle(1'b0, 1'b1, 1'b0, 1'b0); drain();
      rd0 = rd_cnt;
      cycle(1'b0, 1'b1, 1'b0, 1'b0); drain();
      check_eq("step_reads", rd_cnt - rd0, 1);
      check_eq("step_pc", pc_out, 3);
      check_eq("step_busy", busy, 0);

      // backpressure: opcode 0xA held for 5 stall cycles
      prog[3] = 4'hA;
      set_knobs(0, 5, 1'b0);
      v0 = valid_cnt;
      cycle(1'b0, 1'b1, 1'b0, 1'b0); drain();
      check_eq("bp_valid_cycles", valid_cnt - v0, 6);
      check_eq("bp_pc", pc_out, 4);

      // halt request during the fetch wait at PC=5 while run stays high
      set_knobs(1, 0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0); drain();
      halt_done = 1'b0;
      rd0 = hs_count;
      for (int i = 0; i < 50 && hs_count < rd0 + 1; i++) begin
         hp = m_busy && m_phase == PhWait && !halt_done;
         if (hp) halt_done = 1'b1;
         cycle(1'b1, 1'b0, hp, 1'b0);
      end
      check_eq("halt_busy", busy, 0);
      check_eq("halt_pc", pc_out, 6);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("halt_refetch_rd", mem_rd, 1);
      check_eq("halt_refetch_addr", mem_addr, 6);
      drain();

      // wrap from PC=14 with randomized memory latency, stalls and stray data strobes
      set_knobs(3, 3, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      run_instrs(14);
      check_eq("wrap_start_pc", pc_out, 14);
      for (int i = 0; i < 200 && !m_halted; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("wrap_halted", halted, 1);
      check_eq("wrap_pc", pc_out, 0);
      rd0 = rd_cnt;
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
      check_eq("halt_no_reads", rd_cnt - rd0, 0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("restart_halted", halted, 0);
      check_eq("restart_busy", busy, 0);

      // asynchronous reset while waiting for memory at PC=7
      run_instrs(7);
      set_knobs(4, 0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("areset_pre_pc", pc_out, 7);
      #2 nRST = 1'b0;
      #1;
      check_eq("areset_busy", busy, 0);
      check_eq("areset_pc", pc_out, 0);
      check_eq("areset_mem_addr", mem_addr, 0);
      check_eq("areset_instr_out", instr_out, 0);
      check_eq("areset_valid", instr_valid, 0);
      check_eq("areset_rd", mem_rd, 0);
      check_eq("areset_halted", halted, 0);
      model_reset();
      @(posedge CLKin);
      #1;
      nRST = 1'b1;
      run = 0; step = 0; halt_req = 0; restart = 0;
      mem_valid = 1'b1; mem_data = 4'h5;
      @(posedge CLKin);
      #1;
      mem_valid = 1'b0;
      sample_checks();

      // randomized control traffic
      set_knobs(3, 3, 1'b1);
      for (int i = 0; i < 16; i++) prog[i] = 4'($urandom);
      for (int i = 0; i < 600; i++)
         cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
               1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) == 0));
      drain();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
